// File: rtl/avalon_input_pio_if.sv
// avalon_input_pio_if: Avalon-MM slave bus bundle for the input PIO.
// The master drives address/strobes/write data; the slave returns registered read data.
interface avalon_input_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_input_pio.sv
// avalon_input_pio: parametrised Avalon-MM input PIO.
// Each channel is synchronised by two flops, optionally debounced, then edge
// detected into a write-1-to-clear capture register; one IRQ line is driven
// either from masked data (level) or masked edge_capture (edge).
// Build option: define AVALON_INPUT_PIO_DEBOUNCE_EN to instantiate the per-channel
// debounce counters; without it, data is the second synchroniser flop itself.
module avalon_input_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_MODE        = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  avalon_input_pio_if.slave   avs,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] dataPrev_q;
  logic [WIDTH-1:0] irqMask_q;
  logic [WIDTH-1:0] irqMask_d;
  logic [WIDTH-1:0] edgeCapture_q;
  logic [WIDTH-1:0] edgeCapture_d;
  logic [WIDTH-1:0] edgeHit;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             writeEn;
  logic             unusedWriteData;

  assign writeEn         = avs.chipselect & ~avs.write_n;
  assign unusedWriteData = ^avs.writedata;

  // Two-flop synchroniser per channel for the raw asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [CNT_W-1:0] count_q [WIDTH];
  logic [CNT_W-1:0] count_d [WIDTH];

  // Count consecutive disagreeing cycles; accept sync2 once the run is long enough.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      count_d[i] = '0;
      if (sync2_q[i] != data_q[i]) begin
        if (count_q[i] == CNT_LAST) begin
          data_d[i] = sync2_q[i];
        end else begin
          count_d[i] = count_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced data and counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data = data_q;
`else
  logic unusedDebounceCfg;

  assign data              = sync2_q;
  assign unusedDebounceCfg = (DEBOUNCE_CYCLES != 0);
`endif

  // Edge selection against the one-cycle-delayed data.
  always_comb begin
    case (EDGE_TYPE)
      0:       edgeHit = data & ~dataPrev_q;
      1:       edgeHit = ~data & dataPrev_q;
      default: edgeHit = data ^ dataPrev_q;
    endcase
  end

  // Register writes and the read mux; a new edge beats a same-cycle W1C clear.
  always_comb begin
    irqMask_d     = irqMask_q;
    edgeCapture_d = edgeCapture_q;
    readdata_d    = '0;
    if (writeEn && (avs.address == 2'd2)) begin
      irqMask_d = avs.writedata[WIDTH-1:0];
    end
    if (writeEn && (avs.address == 2'd3)) begin
      edgeCapture_d = edgeCapture_q & ~avs.writedata[WIDTH-1:0];
    end
    edgeCapture_d = edgeCapture_d | edgeHit;
    case (avs.address)
      2'd0:    readdata_d[WIDTH-1:0] = data;
      2'd2:    readdata_d[WIDTH-1:0] = irqMask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgeCapture_q;
      default: readdata_d            = '0;
    endcase
  end

  // Control/status registers, delayed data and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataPrev_q    <= '0;
      irqMask_q     <= '0;
      edgeCapture_q <= '0;
      readdata_q    <= '0;
    end else begin
      dataPrev_q    <= data;
      irqMask_q     <= irqMask_d;
      edgeCapture_q <= edgeCapture_d;
      readdata_q    <= readdata_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign irq = (IRQ_MODE == 0) ? |(data & irqMask_q) : |(edgeCapture_q & irqMask_q);

endmodule

// File: tb/tb_avalon_input_pio.sv
// tb_avalon_input_pio: four PIO instances sharing one bus stimulus
// (rising/edge-irq, rising/level-irq, any/edge-irq, falling/level-irq),
// checked every cycle against a window-based reference model plus directed cases.
module tb_avalon_input_pio;
  localparam int N  = 4;
  localparam int DB = 8;
`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
  localparam int WLO = 1;
  localparam int WHI = DB;
`else
  localparam int LAT = 2;
  localparam int WLO = 0;
  localparam int WHI = 0;
`endif

  typedef struct {
    logic [3:0] inVal;
    logic [3:0] maskVal;
    logic       expIrq;
  } levelVec_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic        irqA, irqB, irqC, irqD;
  logic        checkEn;
  int          errors;
  int          checks;

  avalon_input_pio_if bus [N] ();

  for (genvar g = 0; g < N; g++) begin : gBus
    assign bus[g].address    = address;
    assign bus[g].chipselect = chipselect;
    assign bus[g].write_n    = write_n;
    assign bus[g].writedata  = writedata;
  end

  avalon_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(0), .IRQ_MODE(1)) dutA (
    .clk(clk), .reset_n(reset_n), .avs(bus[0]), .in_port(in_port), .irq(irqA));
  avalon_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(0), .IRQ_MODE(0)) dutB (
    .clk(clk), .reset_n(reset_n), .avs(bus[1]), .in_port(in_port), .irq(irqB));
  avalon_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(2), .IRQ_MODE(1)) dutC (
    .clk(clk), .reset_n(reset_n), .avs(bus[2]), .in_port(in_port), .irq(irqC));
  avalon_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(1), .IRQ_MODE(0)) dutD (
    .clk(clk), .reset_n(reset_n), .avs(bus[3]), .in_port(in_port), .irq(irqD));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int eType(input int k);
    case (k)
      2:       return 2;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int iMode(input int k);
    return ((k == 1) || (k == 3)) ? 0 : 1;
  endfunction

  function automatic logic [31:0] getRead(input int k);
    case (k)
      0:       return bus[0].readdata;
      1:       return bus[1].readdata;
      2:       return bus[2].readdata;
      default: return bus[3].readdata;
    endcase
  endfunction

  function automatic logic getIrq(input int k);
    case (k)
      0:       return irqA;
      1:       return irqB;
      2:       return irqC;
      default: return irqD;
    endcase
  endfunction

  // Reference model: a channel adopts a value once the last window of
  // synchronised samples all agree on it; edges come from data vs previous data.
  logic [3:0]  mData, mPrev, mMask;
  logic [3:0]  mCap  [N];
  logic [31:0] mRead [N];
  logic [3:0]  hist  [0:DB];
  logic [3:0]  clrReq;

  assign clrReq = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;

  function automatic logic [3:0] nextData(input logic [3:0] cur, input logic [3:0] h [0:DB]);
    logic [3:0] allOne;
    logic [3:0] allZero;
    allOne  = 4'hF;
    allZero = 4'hF;
    for (int j = WLO; j <= WHI; j++) begin
      allOne  = allOne & h[j];
      allZero = allZero & ~h[j];
    end
    return allOne | (cur & ~allZero);
  endfunction

  function automatic logic [3:0] edgeOf(input int et, input logic [3:0] d, input logic [3:0] p);
    if (et == 0) return d & ~p;
    if (et == 1) return ~d & p;
    return d ^ p;
  endfunction

  function automatic logic [31:0] readMux(input logic [1:0] a, input logic [3:0] d,
                                          input logic [3:0] m, input logic [3:0] c);
    case (a)
      2'd0:    return {28'h0, d};
      2'd2:    return {28'h0, m};
      2'd3:    return {28'h0, c};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic expIrq(input int k);
    return (iMode(k) == 0) ? |(mData & mMask) : |(mCap[k] & mMask);
  endfunction

  // Model state advances on the same edge as the DUTs, from bench-driven inputs only.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mData <= '0;
      mPrev <= '0;
      mMask <= '0;
      for (int k = 0; k < N; k++) begin
        mCap[k]  <= '0;
        mRead[k] <= '0;
      end
      for (int j = 0; j <= DB; j++) hist[j] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        mRead[k] <= readMux(address, mData, mMask, mCap[k]);
        mCap[k]  <= (mCap[k] & ~clrReq) | edgeOf(eType(k), mData, mPrev);
      end
      hist[0] <= in_port;
      for (int j = 1; j <= DB; j++) hist[j] <= hist[j-1];
      mPrev <= mData;
      mData <= nextData(mData, hist);
      if (chipselect && !write_n && address == 2'd2) mMask <= writedata[3:0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, compare each instance's readdata and irq with the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < N; k++) begin
        checkOutput($sformatf("model readdata dut%0d", k), getRead(k), mRead[k]);
        checkOutput($sformatf("model irq dut%0d", k), {31'h0, getIrq(k)}, {31'h0, expIrq(k)});
      end
    end
  end

  // All tasks start and end on a falling clock edge.
  task automatic applyStimulus(input logic [3:0] v, input int cycles);
    in_port = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic busRead(input logic [1:0] a, input int k, input logic [31:0] exp, input string name);
    address = a;
    @(negedge clk);
    checkOutput(name, getRead(k), exp);
  endtask

  task automatic quiesce();
    applyStimulus(4'h0, LAT + 3);
    busWrite(2'd3, 32'hF);
  endtask

  levelVec_t lvl [6];

  initial begin
    lvl[0] = '{4'b1010, 4'b0101, 1'b0};
    lvl[1] = '{4'b1010, 4'b0010, 1'b1};
    lvl[2] = '{4'b1111, 4'b0000, 1'b0};
    lvl[3] = '{4'b0001, 4'b0001, 1'b1};
    lvl[4] = '{4'b0110, 4'b1001, 1'b0};
    lvl[5] = '{4'b1000, 4'b1000, 1'b1};

    errors = 0; checks = 0; checkEn = 1'b0;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 4'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checkEn = 1'b1;
    $display("[TB] reset released, LAT=%0d", LAT);

    // Level mode table on the rising/level instance.
    foreach (lvl[i]) begin
      applyStimulus(lvl[i].inVal, LAT + 3);
      busWrite(2'd2, {28'h0, lvl[i].maskVal});
      checkOutput("level irq", {31'h0, irqB}, {31'h0, lvl[i].expIrq});
      busRead(2'd0, 1, {28'h0, lvl[i].inVal}, "level data read");
      busRead(2'd2, 1, {28'h0, lvl[i].maskVal}, "level mask read");
    end

    // Exact input-to-data latency, observed through level irq and a held read of addr 0.
    quiesce();
    busWrite(2'd2, 32'h1);
    address = 2'd0;
    in_port = 4'h1;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c >= LAT - 1) begin
        checkOutput($sformatf("latency irq c=%0d", c), {31'h0, irqB}, {31'h0, c >= LAT});
        checkOutput($sformatf("latency read c=%0d", c), getRead(1), {31'h0, c >= LAT + 1});
      end
    end

`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
    // A pulse shorter than the debounce window never reaches data or edge_capture.
    quiesce();
    applyStimulus(4'h1, 5);
    applyStimulus(4'h0, LAT + 3);
    busRead(2'd0, 0, 32'h0, "glitch data");
    busRead(2'd3, 0, 32'h0, "glitch capture");
`endif

    // Rising-edge capture with edge irq, W1C clear, falling edge ignored.
    quiesce();
    busWrite(2'd2, 32'hF);
    applyStimulus(4'h4, LAT + 3);
    busRead(2'd3, 0, 32'h4, "rise capture");
    checkOutput("rise irq", {31'h0, irqA}, 32'h1);
    busWrite(2'd3, 32'h4);
    checkOutput("clear irq", {31'h0, irqA}, 32'h0);
    busRead(2'd3, 0, 32'h0, "clear capture");
    applyStimulus(4'h0, LAT + 3);
    busRead(2'd3, 0, 32'h0, "fall ignored");
    checkOutput("fall irq", {31'h0, irqA}, 32'h0);

    // Edge arriving in the same cycle as its W1C clear stays captured.
    quiesce();
    applyStimulus(4'h2, LAT);
    busWrite(2'd3, 32'h2);
    busRead(2'd3, 0, 32'h2, "set wins");

    // Any-edge instance captures both transitions of bit 3.
    quiesce();
    applyStimulus(4'h8, LAT + 3);
    busRead(2'd3, 2, 32'h8, "any rise");
    busWrite(2'd3, 32'h8);
    busRead(2'd3, 2, 32'h0, "any cleared");
    applyStimulus(4'h0, LAT + 3);
    busRead(2'd3, 2, 32'h8, "any fall");

    // Randomised activity against the model.
    for (int i = 0; i < 250; i++) begin
      in_port = 4'($urandom);
      repeat ($urandom_range(1, 12)) begin
        address    = 2'($urandom);
        writedata  = $urandom;
        chipselect = ($urandom_range(0, 2) == 0);
        write_n    = 1'($urandom);
        @(negedge clk);
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // Asynchronous reset in the middle of a write with live inputs.
    busWrite(2'd2, 32'hF);
    applyStimulus(4'hF, LAT + 3);
    address = 2'd2; writedata = 32'hA; chipselect = 1'b1; write_n = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("reset readdata dut%0d", k), getRead(k), 32'h0);
      checkOutput($sformatf("reset irq dut%0d", k), {31'h0, getIrq(k)}, 32'h0);
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; in_port = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      busRead(2'd0, k, 32'h0, $sformatf("post-reset data dut%0d", k));
      busRead(2'd2, k, 32'h0, $sformatf("post-reset mask dut%0d", k));
      busRead(2'd3, k, 32'h0, $sformatf("post-reset capture dut%0d", k));
    end

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_input_pio.md
# avalon_input_pio

- Parametrised Avalon-MM input PIO; successor to the fixed 4-bit button port.
- Adds per-channel two-flop synchronisation, optional debounce, edge detection with a write-1-to-clear edge-capture register, and selectable level or edge interrupt generation.
- Sits between board push-buttons/switches and the Avalon interconnect; drives one IRQ line to the processor.

## Interface

Parameters:
- WIDTH, 4: number of input channels (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a channel changes (≥1; used only with debounce compiled in).
- EDGE_TYPE, 0: edge detected per channel: 0 rising, 1 falling, 2 any.
- IRQ_MODE, 0: 0 level (data & mask), 1 edge (edge_capture & mask).

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- address, input, 2: register select.
- chipselect, input, 1: write qualifier.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data; bits [WIDTH-1:0] used.
- in_port, input, WIDTH: raw asynchronous inputs.
- readdata, output, 32: registered read data, zero-extended above WIDTH.
- irq, output, 1: interrupt request, active high.

## Operation

- Register map:
  - addr 0, data (RO): conditioned input value.
  - addr 1: reserved; reads 0, writes ignored.
  - addr 2, irq_mask (RW).
  - addr 3, edge_capture (R/W1C).
- Input path:
  - in_port → sync1 → sync2 (two flops per channel) → conditioner → `data`.
  - `data_prev` register holds `data` delayed one cycle.
- Debounce (with macro), per channel:
  - Counter width clog2(DEBOUNCE_CYCLES+1).
  - While sync2 == data, counter holds 0.
  - While they differ, counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still differs, `data` takes sync2 on the next edge and the counter returns to 0.
  - Any return to equality before then clears the counter. Glitches shorter than DEBOUNCE_CYCLES never reach `data`.
- Edge detect, per bit:
  - rising = data & ~data_prev.
  - falling = ~data & data_prev.
  - any = data ^ data_prev.
  - A detected edge sets the edge_capture bit.
- edge_capture clear: write to addr 3 (chipselect & ~write_n) clears each bit whose writedata bit is 1. A bit both set and cleared in the same cycle ends set (set wins).
- irq_mask: write to addr 2 loads writedata[WIDTH-1:0].
- readdata: loaded every cycle from the address mux, independent of chipselect; unused bits are 0.
- irq is combinational from registers:
  - IRQ_MODE 0: |(data & irq_mask).
  - IRQ_MODE 1: |(edge_capture & irq_mask).
- Reset value 0 for sync1, sync2, data, data_prev, debounce counters, irq_mask, edge_capture and readdata; irq is therefore 0.
- Reset is asynchronous and may assert mid-debounce or mid-write; every register returns to 0 immediately.
- Power-up/reset never produces a spurious edge: data and data_prev both reset to 0.

## Timing

- Read latency: 1 cycle. readdata reflects the address presented on the previous clock edge.
- Write effect: visible in the register on the edge after the write cycle, in readdata one cycle later.
- in_port change → data:
  - Without debounce: 2 cycles.
  - With debounce: 2 + DEBOUNCE_CYCLES cycles, input held stable throughout.
- data change → edge_capture set: 1 cycle. irq follows combinationally in the same cycle as the register update.
- Level-mode irq follows data in the same cycle data updates.

## Configuration

- AVALON_INPUT_PIO_DEBOUNCE_EN defined: debounce counters instantiated as in Operation.
- Macro undefined:
  - No counters; data = sync2 registered directly (data is sync2 delayed one flop is NOT added; data equals sync2).
  - DEBOUNCE_CYCLES is ignored.
  - All other behaviour is identical.

## Test plan

- Reset: assert reset_n=0 mid-activity → readdata=0, irq=0, and reads of addrs 0/2/3 return 0 after release.
- Debounce (macro on, DEBOUNCE_CYCLES=8, WIDTH=4):
  - in_port=4'b0001 held 5 cycles then back to 0 → data stays 0, edge_capture stays 0.
  - Held ≥10 cycles → data=1 exactly 10 cycles after the change.
- Edge capture (EDGE_TYPE=0, IRQ_MODE=1, mask=4'hF):
  - Rise on bit 2 → edge_capture=4'h4, irq=1.
  - Write 4'h4 to addr 3 → edge_capture=0, irq=0.
  - Falling edge on bit 2 → no capture.
- Set-wins: edge on bit 1 in the same cycle as a W1C write of 4'h2 → edge_capture bit1 remains 1.
- Level mode (IRQ_MODE=0): data=4'b1010.
  - mask=4'b0101 → irq=0.
  - Write mask 4'b0010 → irq=1 on the next cycle; read addr 2 returns 32'h2.
- EDGE_TYPE=2: toggle bit 3 0→1→0 with a clear between → edge_capture bit3 set after each transition.
